// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: load/store width codes, MEM-stage FSM states and alignment helpers
package rv32_mem_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_t;
  // Byte offset after forcing halfword/word accesses onto their natural boundary
  function automatic logic [1:0] force_align(input logic [2:0] f, input logic [1:0] a);
    return f[1:0] == F3_SW[1:0] ? 2'b00 : f[1:0] == F3_SH[1:0] ? {a[1], 1'b0} : a;
  endfunction
  // Halfword on an odd byte or word off a word boundary
  function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
    return (f[1:0] == F3_SH[1:0] && a[0]) || (f[1:0] == F3_SW[1:0] && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores (BE/WDATA) and loads (right-aligned word)
module mem_lane_align
  import rv32_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);
  // Lane enables follow access width; data moves by whole bytes
  always_comb begin
    be = func3[1:0] == F3_SB[1:0] ? 4'b0001 << off : func3[1:0] == F3_SH[1:0] ? 4'b0011 << off : 4'b1111;
    wdata = store_data << {off, 3'b000};
    load_data = rdata >> {off, 3'b000};
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32 MEM stage, req/ack data-memory access with stall; MEM_MISALIGN_TRAP_EN enables misalignment trap
module mem_access_stage
  import rv32_mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EX_VALID,
  input  logic [2:0]      EX_FUNC3,
  input  logic            EX_MEM_READ,
  input  logic            EX_MEM_WRITE,
  input  logic            EX_WRITE_ENABLE,
  input  logic            EX_DATA_MEM_SELECT,
  input  logic [XLEN-1:0] EX_JAL_SELECTED,
  input  logic [XLEN-1:0] EX_STORE_DATA,
  input  logic [RD_W-1:0] EX_RD,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [XLEN-1:0] DMEM_ADDR,
  output logic [XLEN-1:0] DMEM_WDATA,
  output logic [3:0]      DMEM_BE,
  input  logic [XLEN-1:0] DMEM_RDATA,
  input  logic            DMEM_ACK,
  output logic            MEM_STALL,
  output logic [2:0]      MEM_FUNC3,
  output logic            MEM_WRITE_ENABLE,
  output logic            MEM_DATA_MEM_SELECT,
  output logic [XLEN-1:0] MEM_JAL_SELECTED,
  output logic [XLEN-1:0] MEM_DATA_OUT,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            MEM_MISALIGN,
`endif
  output logic [RD_W-1:0] MEM_RD
);
  mem_state_t state, next_state;
  logic [XLEN-1:0] lat_jal, lat_sd, wdata, load_data;
  logic [2:0] lat_func3;
  logic [1:0] lat_off;
  logic [RD_W-1:0] lat_rd;
  logic [3:0] be;
  logic lat_store, lat_we, lat_sel, busy, mem_op, trap, start;
  assign mem_op = EX_VALID && (EX_MEM_READ || EX_MEM_WRITE);
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op && misaligned(EX_FUNC3, EX_JAL_SELECTED[1:0]);
`else
  assign trap = 1'b0;
`endif
  assign start = mem_op && !trap;
  assign busy = state == MEM_BUSY;
  mem_lane_align #(.XLEN(XLEN)) u_align (
    .func3(lat_func3),
    .off(lat_off),
    .store_data(lat_sd),
    .rdata(DMEM_RDATA),
    .be(be),
    .wdata(wdata),
    .load_data(load_data)
  );
  // State register; reset abandons any outstanding request
  always_ff @(posedge CLK)
    state <= RST ? MEM_IDLE : next_state;
  // Enter BUSY on an accepted access, leave on the ack cycle
  always_comb
    next_state = busy ? (DMEM_ACK ? MEM_IDLE : MEM_BUSY) : (start ? MEM_BUSY : MEM_IDLE);
  // Memory interface driven only while BUSY; stall until the ack arrives
  always_comb begin
    DMEM_REQ = busy;
    DMEM_WE = busy && lat_store;
    DMEM_BE = (busy && lat_store) ? be : 4'b0000;
    DMEM_ADDR = {lat_jal[XLEN-1:2], 2'b00};
    DMEM_WDATA = wdata;
    MEM_STALL = busy ? !DMEM_ACK : start;
  end
  // Access latches and WB-facing registers; anything not completing this cycle is a bubble
  always_ff @(posedge CLK) begin
    if (RST) begin
      {lat_jal, lat_sd, lat_func3, lat_off, lat_rd, lat_store, lat_we, lat_sel} <= '0;
      {MEM_FUNC3, MEM_WRITE_ENABLE, MEM_DATA_MEM_SELECT, MEM_JAL_SELECTED, MEM_DATA_OUT, MEM_RD} <= '0;
    end else begin
      if (!busy && start) begin
        lat_jal <= EX_JAL_SELECTED;
        lat_sd <= EX_STORE_DATA;
        lat_func3 <= EX_FUNC3;
        lat_off <= force_align(EX_FUNC3, EX_JAL_SELECTED[1:0]);
        lat_rd <= EX_RD;
        lat_store <= EX_MEM_WRITE;
        lat_we <= EX_WRITE_ENABLE;
        lat_sel <= EX_DATA_MEM_SELECT;
      end
      if (busy) begin
        MEM_WRITE_ENABLE <= DMEM_ACK && lat_we && !lat_store;
        if (DMEM_ACK) begin
          MEM_FUNC3 <= lat_func3;
          MEM_DATA_MEM_SELECT <= lat_sel;
          MEM_JAL_SELECTED <= lat_jal;
          MEM_DATA_OUT <= load_data;
          MEM_RD <= lat_rd;
        end
      end else if (EX_VALID && !mem_op) begin
        MEM_FUNC3 <= EX_FUNC3;
        MEM_WRITE_ENABLE <= EX_WRITE_ENABLE;
        MEM_DATA_MEM_SELECT <= EX_DATA_MEM_SELECT;
        MEM_JAL_SELECTED <= EX_JAL_SELECTED;
        MEM_RD <= EX_RD;
      end else begin
        MEM_WRITE_ENABLE <= 1'b0;
        MEM_RD <= trap ? EX_RD : MEM_RD;
      end
    end
  end
`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle misalignment flag alongside MEM_RD
  always_ff @(posedge CLK)
    MEM_MISALIGN <= !RST && !busy && trap;
`endif
endmodule
